vend_controller: RTL and testbench

Central sequencing FSM for the micro vending machine. Consumes the debounced single-cycle key and coin pulses produced by the key filter stage. Tracks goods selection, coin accumulation, purchase confirmation, change and cancel. Drives the need/input/change amounts consumed by the seven-segment display block, plus vend/refund status pulses.

---
 rtl/vend_pkg.sv | 42 ++++
 rtl/vend_coin_accum.sv | 45 ++++
 rtl/vend_controller.sv | 178 +++++++++++++++++
 tb/tb_vend_controller.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending machine controller: state codes,
// coin values, default prices and the money datapath width.
package vend_pkg;

   localparam int MONEY_W    = 8;
   localparam int COIN_SUM_W = 7;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SELECT = 2'd1,
      ST_PAY    = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [COIN_SUM_W-1:0] COIN_ONE    = 7'd1;
   localparam logic [COIN_SUM_W-1:0] COIN_FIVE   = 7'd5;
   localparam logic [COIN_SUM_W-1:0] COIN_TEN    = 7'd10;
   localparam logic [COIN_SUM_W-1:0] COIN_TWENTY = 7'd20;
   localparam logic [COIN_SUM_W-1:0] COIN_FIFTY  = 7'd50;

   localparam logic [MONEY_W-1:0] PRICE0_DEF    = 8'd3;
   localparam logic [MONEY_W-1:0] PRICE1_DEF    = 8'd5;
   localparam logic [MONEY_W-1:0] PRICE2_DEF    = 8'd8;
   localparam logic [MONEY_W-1:0] PRICE3_DEF    = 8'd12;
   localparam logic [MONEY_W-1:0] MAX_INPUT_DEF = 8'd99;

   // Worst case 1+5+10+20+50 = 86, so 7 bits never overflow.
   function automatic logic [COIN_SUM_W-1:0] coin_sum(
      input logic one,
      input logic five,
      input logic ten,
      input logic twenty,
      input logic fifty
   );
      coin_sum = (one    ? COIN_ONE    : '0) +
                 (five   ? COIN_FIVE   : '0) +
                 (ten    ? COIN_TEN    : '0) +
                 (twenty ? COIN_TWENTY : '0) +
                 (fifty  ? COIN_FIFTY  : '0);
   endfunction

endpackage

// File: rtl/vend_coin_accum.sv
// Inserted-money accumulator: sums this cycle's coin pulses, adds them when the
// total stays within the display limit, otherwise refuses the whole batch.
module vend_coin_accum
   import vend_pkg::*;
#(
   parameter logic [MONEY_W-1:0] MAX_INPUT = MAX_INPUT_DEF
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   input  logic               clear,
   input  logic               enable,
   input  logic               refuse,
   input  logic               in_money_one,
   input  logic               in_money_five,
   input  logic               in_money_ten,
   input  logic               in_money_twenty,
   input  logic               in_money_fifty,
   output logic [MONEY_W-1:0] input_money,
   output logic               coin_reject
);

   logic [COIN_SUM_W-1:0] sum;
   logic [MONEY_W:0]      total;
   logic                  over;

   assign sum   = coin_sum(in_money_one, in_money_five, in_money_ten,
                           in_money_twenty, in_money_fifty);
   assign total = {1'b0, input_money} + {2'b00, sum};
   assign over  = (total > {1'b0, MAX_INPUT});

   // refuse rejects any non-empty batch; enable alone only rejects on overflow
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         input_money <= '0;
         coin_reject <= 1'b0;
      end else begin
         coin_reject <= (sum != '0) && (refuse || (enable && over));
         if (clear)
            input_money <= '0;
         else if (enable && !refuse && !over)
            input_money <= total[MONEY_W-1:0];
      end
   end

endmodule

// File: rtl/vend_controller.sv
// Vending machine sequencing FSM: selection, payment, change/refund and result hold.
// Build option AUTO_CHANGE_EN: leave PAY automatically once enough money is inserted.
//
// state  | meaning
// IDLE   | waiting for a goods key, all amounts zero
// SELECT | cycling through goods, waiting for confirm or cancel
// PAY    | accepting coins against the frozen selection
// DONE   | holding change/refund result for display, then back to IDLE
module vend_controller
   import vend_pkg::*;
#(
   parameter logic [MONEY_W-1:0] PRICE0      = PRICE0_DEF,
   parameter logic [MONEY_W-1:0] PRICE1      = PRICE1_DEF,
   parameter logic [MONEY_W-1:0] PRICE2      = PRICE2_DEF,
   parameter logic [MONEY_W-1:0] PRICE3      = PRICE3_DEF,
   parameter logic [MONEY_W-1:0] MAX_INPUT   = MAX_INPUT_DEF,
   parameter int unsigned        HOLD_CYCLES = 100_000_000
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   input  logic               sys_Goods,
   input  logic               sys_Confirm,
   input  logic               sys_Change,
   input  logic               sys_Cancel,
   input  logic               in_money_one,
   input  logic               in_money_five,
   input  logic               in_money_ten,
   input  logic               in_money_twenty,
   input  logic               in_money_fifty,
   output logic [1:0]         goods_idx,
   output logic [MONEY_W-1:0] need_money,
   output logic [MONEY_W-1:0] input_money,
   output logic [MONEY_W-1:0] change_money,
   output logic [2:0]         state_o,
   output logic               vend_pulse,
   output logic               refund_flag,
   output logic               coin_reject
);

   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

   function automatic logic [MONEY_W-1:0] price_of(input logic [1:0] idx);
      case (idx)
         2'd0:    price_of = PRICE0;
         2'd1:    price_of = PRICE1;
         2'd2:    price_of = PRICE2;
         default: price_of = PRICE3;
      endcase
   endfunction

   state_t             state, state_nxt;
   logic [1:0]         idx_nxt;
   logic [MONEY_W-1:0] need_nxt, change_nxt;
   logic               vend_nxt, refund_nxt;
   logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
   logic               pay_ok, go_change;
   logic               acc_clear, acc_enable, acc_refuse;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state        <= ST_IDLE;
         goods_idx    <= '0;
         need_money   <= '0;
         change_money <= '0;
         vend_pulse   <= 1'b0;
         refund_flag  <= 1'b0;
         hold_cnt     <= '0;
      end else begin
         state        <= state_nxt;
         goods_idx    <= idx_nxt;
         need_money   <= need_nxt;
         change_money <= change_nxt;
         vend_pulse   <= vend_nxt;
         refund_flag  <= refund_nxt;
         hold_cnt     <= hold_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      idx_nxt    = goods_idx;
      need_nxt   = need_money;
      change_nxt = change_money;
      vend_nxt   = 1'b0;
      refund_nxt = refund_flag;
      hold_nxt   = hold_cnt;
      acc_enable = 1'b0;
      acc_refuse = 1'b0;
      pay_ok     = (input_money >= need_money);
`ifdef AUTO_CHANGE_EN
      go_change  = pay_ok;
`else
      go_change  = pay_ok && sys_Change;
`endif

      case (state)
         ST_IDLE: begin
            if (sys_Goods) begin
               state_nxt = ST_SELECT;
               idx_nxt   = 2'd0;
               need_nxt  = PRICE0;
            end
         end
         ST_SELECT: begin
            if (sys_Cancel) begin
               state_nxt = ST_IDLE;
               idx_nxt   = 2'd0;
               need_nxt  = '0;
            end else if (sys_Confirm) begin
               state_nxt = ST_PAY;
            end else if (sys_Goods) begin
               idx_nxt   = goods_idx + 2'd1;
               need_nxt  = price_of(goods_idx + 2'd1);
            end
         end
         ST_PAY: begin
            // any key press in the same cycle takes the coins' slot
            acc_enable = 1'b1;
            acc_refuse = sys_Cancel || sys_Change || go_change;
            if (sys_Cancel) begin
               state_nxt  = ST_DONE;
               change_nxt = input_money;
               refund_nxt = 1'b1;
               hold_nxt   = HOLD_LOAD;
            end else if (go_change) begin
               state_nxt  = ST_DONE;
               change_nxt = input_money - need_money;
               vend_nxt   = 1'b1;
               refund_nxt = 1'b0;
               hold_nxt   = HOLD_LOAD;
            end
         end
         ST_DONE: begin
            acc_refuse = 1'b1;
            if (hold_cnt == '0) begin
               state_nxt  = ST_IDLE;
               idx_nxt    = 2'd0;
               need_nxt   = '0;
               change_nxt = '0;
               refund_nxt = 1'b0;
            end else begin
               hold_nxt   = hold_cnt - HOLD_W'(1);
            end
         end
         default: begin
            state_nxt  = ST_IDLE;
            idx_nxt    = 2'd0;
            need_nxt   = '0;
            change_nxt = '0;
            refund_nxt = 1'b0;
            hold_nxt   = '0;
         end
      endcase

      acc_clear = (state_nxt == ST_IDLE);
   end

   assign state_o = {1'b0, state};

   vend_coin_accum #(
      .MAX_INPUT (MAX_INPUT)
   ) u_coin_accum (
      .sys_clk         (sys_clk),
      .sys_rst_n       (sys_rst_n),
      .clear           (acc_clear),
      .enable          (acc_enable),
      .refuse          (acc_refuse),
      .in_money_one    (in_money_one),
      .in_money_five   (in_money_five),
      .in_money_ten    (in_money_ten),
      .in_money_twenty (in_money_twenty),
      .in_money_fifty  (in_money_fifty),
      .input_money     (input_money),
      .coin_reject     (coin_reject)
   );

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: directed scenarios plus random key/coin
// traffic, compared every cycle against a transaction-level model of the machine.
module tb_vend_controller;

   localparam int HOLD = 16;
   localparam int MAXI = 99;
`ifdef AUTO_CHANGE_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   localparam logic [8:0] K_G  = 9'h100;
   localparam logic [8:0] K_CF = 9'h080;
   localparam logic [8:0] K_CH = 9'h040;
   localparam logic [8:0] K_CA = 9'h020;
   localparam logic [8:0] C50  = 9'h010;
   localparam logic [8:0] C20  = 9'h008;
   localparam logic [8:0] C10  = 9'h004;
   localparam logic [8:0] C5   = 9'h002;
   localparam logic [8:0] C1   = 9'h001;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n;
   logic       i_goods, i_confirm, i_change, i_cancel;
   logic       i_one, i_five, i_ten, i_twenty, i_fifty;
   logic [1:0] goods_idx;
   logic [7:0] need_money, input_money, change_money;
   logic [2:0] state_o;
   logic       vend_pulse, refund_flag, coin_reject;

   int n_checks = 0;
   int n_fail   = 0;

   vend_controller #(.HOLD_CYCLES(HOLD)) dut (
      .sys_clk         (sys_clk),
      .sys_rst_n       (sys_rst_n),
      .sys_Goods       (i_goods),
      .sys_Confirm     (i_confirm),
      .sys_Change      (i_change),
      .sys_Cancel      (i_cancel),
      .in_money_one    (i_one),
      .in_money_five   (i_five),
      .in_money_ten    (i_ten),
      .in_money_twenty (i_twenty),
      .in_money_fifty  (i_fifty),
      .goods_idx       (goods_idx),
      .need_money      (need_money),
      .input_money     (input_money),
      .change_money    (change_money),
      .state_o         (state_o),
      .vend_pulse      (vend_pulse),
      .refund_flag     (refund_flag),
      .coin_reject     (coin_reject)
   );

   always #5 sys_clk = ~sys_clk;

   // Model: mode 0 idle, 1 choosing, 2 paying, 3 showing result
   int price [4] = '{3, 5, 8, 12};
   int m_state = 0, m_idx = 0, m_need = 0, m_in = 0, m_change = 0, m_done_cycles = 0;
   bit m_vend = 0, m_refund = 0, m_rej = 0;

   task automatic model_clear();
      m_state = 0; m_idx = 0; m_need = 0; m_in = 0; m_change = 0;
      m_refund = 0; m_vend = 0; m_rej = 0; m_done_cycles = 0;
   endtask

   task automatic model_step();
      int  sum;
      bit  key_busy, enough, sell;
      sum = (i_one ? 1 : 0) + (i_five ? 5 : 0) + (i_ten ? 10 : 0) +
            (i_twenty ? 20 : 0) + (i_fifty ? 50 : 0);
      m_vend = 0;
      m_rej  = 0;
      if (m_state == 0) begin
         if (i_goods) begin m_state = 1; m_idx = 0; m_need = price[0]; end
      end else if (m_state == 1) begin
         if (i_cancel) begin m_state = 0; m_idx = 0; m_need = 0; end
         else if (i_confirm) m_state = 2;
         else if (i_goods) begin m_idx = (m_idx + 1) % 4; m_need = price[m_idx]; end
      end else if (m_state == 2) begin
         enough   = (m_in >= m_need);
         sell     = enough && (i_change || AUTO);
         key_busy = i_cancel || i_change || sell;
         if (sum > 0) begin
            if (key_busy || (m_in + sum > MAXI)) m_rej = 1;
            else if (!i_cancel && !sell) m_in = m_in + sum;
         end
         if (i_cancel) begin
            m_state = 3; m_change = m_in; m_refund = 1; m_done_cycles = 0;
         end else if (sell) begin
            m_state = 3; m_change = m_in - m_need; m_vend = 1; m_refund = 0; m_done_cycles = 0;
         end
      end else begin
         if (sum > 0) m_rej = 1;
         m_done_cycles++;
         if (m_done_cycles == HOLD) begin
            m_state = 0; m_idx = 0; m_need = 0; m_in = 0; m_change = 0; m_refund = 0;
         end
      end
   endtask

   always @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) model_clear();
      else            model_step();
   end

   always @(negedge sys_clk) begin
      n_checks++;
      if (int'(state_o) != m_state || int'(goods_idx) != m_idx || int'(need_money) != m_need ||
          int'(input_money) != m_in || int'(change_money) != m_change ||
          vend_pulse != m_vend || refund_flag != m_refund || coin_reject != m_rej) begin
         n_fail++;
         $display("FAIL cycle_cmp t=%0t dut st=%0d idx=%0d need=%0d in=%0d chg=%0d vend=%0d ref=%0d rej=%0d model st=%0d idx=%0d need=%0d in=%0d chg=%0d vend=%0d ref=%0d rej=%0d",
                  $time, state_o, goods_idx, need_money, input_money, change_money, vend_pulse,
                  refund_flag, coin_reject, m_state, m_idx, m_need, m_in, m_change, m_vend,
                  m_refund, m_rej);
      end
   end

   task automatic pin(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic step_in(input logic [8:0] v);
      {i_goods, i_confirm, i_change, i_cancel, i_fifty, i_twenty, i_ten, i_five, i_one} = v;
      @(posedge sys_clk);
      #1;
      {i_goods, i_confirm, i_change, i_cancel, i_fifty, i_twenty, i_ten, i_five, i_one} = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   function automatic logic [8:0] rand_in();
      logic [8:0] v;
      v[8] = ($urandom % 100) < 15;
      v[7] = ($urandom % 100) < 10;
      v[6] = ($urandom % 100) < 5;
      v[5] = ($urandom % 100) < 3;
      for (int b = 0; b < 5; b++) v[b] = ($urandom % 100) < 12;
      return v;
   endfunction

   initial begin
      sys_rst_n = 1'b0;
      {i_goods, i_confirm, i_change, i_cancel, i_fifty, i_twenty, i_ten, i_five, i_one} = '0;
      repeat (2) @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b1;
      pin("reset_outputs", int'({goods_idx, need_money, input_money, change_money,
                                state_o, vend_pulse, refund_flag, coin_reject}), 0);

      // reset mid-payment discards the money at once
      repeat (4) step_in(K_G);
      step_in(K_CF);
      step_in(C10);
      step_in(C5);
      pin("pay_input_15", int'(input_money), 15);
      sys_rst_n = 1'b0;
      #1;
      pin("async_rst_outputs", int'({goods_idx, need_money, input_money, change_money,
                                    state_o, vend_pulse, refund_flag, coin_reject}), 0);
      pin("async_rst_state", int'(state_o), 0);
      sys_rst_n = 1'b1;

      // three goods presses then confirm
      repeat (3) step_in(K_G);
      step_in(K_CF);
      pin("sel_idx2", int'(goods_idx), 2);
      pin("sel_need8", int'(need_money), 8);
      pin("sel_state_pay", int'(state_o), 2);
      pin("model_idx2", m_idx, 2);
      step_in(K_CA);
      idle(HOLD);
      pin("back_idle", int'(state_o), 0);

      // five presses wrap back to index 0
      repeat (5) step_in(K_G);
      pin("wrap_idx0", int'(goods_idx), 0);
      pin("wrap_need3", int'(need_money), 3);
      step_in(K_CA);
      pin("sel_cancel_idle", int'(state_o), 0);

      // buy index 3 with 10+5
      repeat (4) step_in(K_G);
      step_in(K_CF);
      step_in(C10);
      step_in(C5);
      step_in(K_CH);
      pin("buy_change3", int'(change_money), 3);
      pin("buy_vend", int'(vend_pulse), 1);
      pin("model_change3", m_change, 3);
      idle(1);
      pin("buy_vend_single", int'(vend_pulse), 0);
      idle(HOLD - 1);
      pin("hold_expired_state", int'(state_o), 0);
      pin("hold_expired_amounts", int'({need_money, input_money, change_money}), 0);

`ifndef AUTO_CHANGE_EN
      // overflow refusal and a same-cycle double coin
      step_in(K_G);
      step_in(K_CF);
      step_in(C50);
      step_in(C10);
      step_in(C50);
      pin("ovf_reject", int'(coin_reject), 1);
      pin("ovf_input60", int'(input_money), 60);
      step_in(C20 | C10);
      pin("dual_input90", int'(input_money), 90);
      pin("model_in90", m_in, 90);
      step_in(K_CA);
      idle(HOLD);
`endif

      // change ignored when short, then cancel refunds
      repeat (2) step_in(K_G);
      step_in(K_CF);
      repeat (4) step_in(C1);
      step_in(K_CH);
      pin("short_change_state", int'(state_o), 2);
      pin("short_change_vend", int'(vend_pulse), 0);
      step_in(K_CA);
      pin("cancel_change4", int'(change_money), 4);
      pin("cancel_refund", int'(refund_flag), 1);
      pin("cancel_no_vend", int'(vend_pulse), 0);
      idle(HOLD);

      // cancel beats change and coins in the same cycle
      repeat (3) step_in(K_G);
      step_in(K_CF);
      step_in(C10);
      step_in(K_CA | K_CH | C1);
      pin("prio_change10", int'(change_money), 10);
      pin("prio_refund", int'(refund_flag), 1);
      pin("prio_reject", int'(coin_reject), 1);
      pin("prio_no_vend", int'(vend_pulse), 0);
      idle(HOLD);

`ifdef AUTO_CHANGE_EN
      repeat (3) step_in(K_G);
      step_in(K_CF);
      step_in(C5);
      step_in(C5);
      pin("auto_wait_state", int'(state_o), 2);
      idle(1);
      pin("auto_done_state", int'(state_o), 3);
      pin("auto_change2", int'(change_money), 2);
      pin("auto_vend", int'(vend_pulse), 1);
      idle(HOLD);
`endif

      for (int c = 0; c < 3000; c++) step_in(rand_in());
      idle(HOLD + 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
